hold_fifo_gen: RTL

Parametrised hold buffer between the Aurora receiver and the downstream write FIFO.
- Absorbs received words in an inferred circular buffer.
- Drains them into the downstream FIFO whenever that FIFO's almost-full flag is low.
- Reports free-slot credit back to the Aurora transmitter, less a configurable headroom.
- Adds over the previous generation: generic width and depth, synchronous flush, sticky overflow detection and an occupancy count output.

---
 rtl/hold_fifo_gen.sv | 58 +++++
 1 files changed

// File: rtl/hold_fifo_gen.sv
// hold_fifo_gen: hold buffer between Aurora RX and downstream FIFO with credit, flush, overflow and occupancy.
// Optional HOLD_FIFO_PEAK_EN adds peak_o, the maximum occupancy since reset or flush.
module hold_fifo_gen #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int HEADROOM = 40,
  parameter int CREDIT_W = 18
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                flush_i,
  input  logic                wr_i,
  input  logic [DATA_W-1:0]   wr_dat_i,
  output logic                fifo_wr_o,
  output logic [DATA_W-1:0]   fifo_wr_dat_o,
  input  logic                fifo_afull_i,
  output logic [CREDIT_W-1:0] empty_slots_o,
  output logic [ADDR_W:0]     count_o,
  output logic                overflow_o
`ifdef HOLD_FIFO_PEAK_EN
  ,
  output logic [ADDR_W:0]     peak_o
`endif
);
  localparam logic [ADDR_W:0]     FULL  = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [CREDIT_W-1:0] AVAIL = CREDIT_W'(2**ADDR_W - HEADROOM);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              rd, wa;
  assign rd = ~fifo_afull_i & (count_o != '0) & ~flush_i;
  // a full buffer still accepts a write when a word leaves in the same cycle
  assign wa = wr_i & ~flush_i & ((count_o != FULL) | rd);
  always_ff @(posedge clk_i)
    if (wa) mem[wr_ptr] <= wr_dat_i;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_o       <= '0;
      fifo_wr_o     <= 1'b0;
      fifo_wr_dat_o <= '0;
      overflow_o    <= 1'b0;
      empty_slots_o <= '0;
    end else begin
      wr_ptr        <= flush_i ? '0 : wr_ptr + ADDR_W'(wa);
      rd_ptr        <= flush_i ? '0 : rd_ptr + ADDR_W'(rd);
      count_o       <= flush_i ? '0 : count_o + (ADDR_W+1)'(wa) - (ADDR_W+1)'(rd);
      fifo_wr_o     <= rd;
      if (rd) fifo_wr_dat_o <= mem[rd_ptr];
      overflow_o    <= ~flush_i & (overflow_o | (wr_i & ~wa));
      empty_slots_o <= (CREDIT_W'(count_o) > AVAIL) ? '0 : AVAIL - CREDIT_W'(count_o);
    end
`ifdef HOLD_FIFO_PEAK_EN
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) peak_o <= '0;
    else peak_o <= flush_i ? '0 : (count_o > peak_o ? count_o : peak_o);
`endif
endmodule
